// File: rtl/ball_collision_det_pkg.sv
// Shared ball-game definitions: brick-grid geometry defaults and the
// collision-scan FSM encoding.
package ball_game_pkg;

  localparam int DEF_BALL_R  = 10;
  localparam int DEF_BRICK_W = 128;
  localparam int DEF_BRICK_H = 32;
  localparam int DEF_GRID_X0 = 0;
  localparam int DEF_GRID_Y0 = 64;
  localparam int DEF_COLS    = 8;
  localparam int NUM_BRICKS  = 16;
  localparam int IDX_W       = 4;
  localparam int POS_W       = 12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SCAN = ST_SCAN,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/ball_collision_det_if.sv
// Scan request / result bundle between the ball position logic (master)
// and the collision detector (slave).
interface ball_collision_det_if;
  import ball_game_pkg::*;

  // scan_start is a one-cycle request honoured only while busy is low;
  // det_valid pulses for one cycle when collision_det takes a new value.
  logic                  scan_start;
  logic [POS_W-1:0]      x_pos;
  logic [POS_W-1:0]      y_pos;
  logic [NUM_BRICKS-1:0] brick_alive;
  logic [NUM_BRICKS-1:0] collision_det;
  logic                  det_valid;
  logic                  busy;
  state_e                dbg_state;

  modport master (
    output scan_start, x_pos, y_pos, brick_alive,
    input  collision_det, det_valid, busy, dbg_state
  );

  modport slave (
    input  scan_start, x_pos, y_pos, brick_alive,
    output collision_det, det_valid, busy, dbg_state
  );

endinterface

// File: rtl/ball_collision_det_brick_hit.sv
// Combinational ball-vs-brick bounding-box test for one brick index.
// Compares in 13 bits with the radius added on both sides, so no subtraction.
module brick_hit
  import ball_game_pkg::*;
#(
  parameter int BALL_R  = DEF_BALL_R,
  parameter int BRICK_W = DEF_BRICK_W,
  parameter int BRICK_H = DEF_BRICK_H,
  parameter int GRID_X0 = DEF_GRID_X0,
  parameter int GRID_Y0 = DEF_GRID_Y0,
  parameter int COLS    = DEF_COLS
) (
  input  logic [POS_W-1:0] x_i,
  input  logic [POS_W-1:0] y_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             alive_i,
  output logic             hit_o
);

  logic [12:0] x_ext, y_ext, r;
  logic [12:0] x0, x1, y0, y1;

  assign x_ext = {1'b0, x_i};
  assign y_ext = {1'b0, y_i};
  assign r     = 13'(BALL_R);

  assign x0 = 13'(GRID_X0 + (int'(idx_i) % COLS) * BRICK_W);
  assign x1 = 13'(GRID_X0 + (int'(idx_i) % COLS) * BRICK_W + BRICK_W - 1);
  assign y0 = 13'(GRID_Y0 + (int'(idx_i) / COLS) * BRICK_H);
  assign y1 = 13'(GRID_Y0 + (int'(idx_i) / COLS) * BRICK_H + BRICK_H - 1);

  assign hit_o = alive_i
               & (x_ext + r >= x0) & (x_ext <= x1 + r)
               & (y_ext + r >= y0) & (y_ext <= y1 + r);

endmodule

// File: rtl/ball_collision_det.sv
// Sequential collision detector: latches the ball on scan_start, tests one
// brick per clock, then publishes a 16-bit hit vector held until the next scan.
module ball_collision_det
  import ball_game_pkg::*;
#(
  parameter int BALL_R  = DEF_BALL_R,
  parameter int BRICK_W = DEF_BRICK_W,
  parameter int BRICK_H = DEF_BRICK_H,
  parameter int GRID_X0 = DEF_GRID_X0,
  parameter int GRID_Y0 = DEF_GRID_Y0,
  parameter int COLS    = DEF_COLS
) (
  input  logic           pclk,
  input  logic           reset,
  ball_collision_det_if.slave bus
);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [POS_W-1:0]      x_q, x_d, y_q, y_d;
  logic [NUM_BRICKS-1:0] alive_q, alive_d;
  logic [NUM_BRICKS-1:0] acc_q, acc_d;
  logic [NUM_BRICKS-1:0] det_q, det_d;
  logic                  valid_q, valid_d;
  logic                  hit;

  brick_hit #(
    .BALL_R (BALL_R),
    .BRICK_W(BRICK_W),
    .BRICK_H(BRICK_H),
    .GRID_X0(GRID_X0),
    .GRID_Y0(GRID_Y0),
    .COLS   (COLS)
  ) u_brick_hit (
    .x_i    (x_q),
    .y_i    (y_q),
    .idx_i  (idx_q),
    .alive_i(alive_q[idx_q]),
    .hit_o  (hit)
  );

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      alive_q <= '0;
      acc_q   <= '0;
      det_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      alive_q <= alive_d;
      acc_q   <= acc_d;
      det_q   <= det_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    alive_d = alive_q;
    acc_d   = acc_q;
    det_d   = det_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.scan_start) begin
          state_d = SCAN;
          x_d     = bus.x_pos;
          y_d     = bus.y_pos;
          alive_d = bus.brick_alive;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      SCAN: begin
        acc_d[idx_q] = hit;
        idx_d        = idx_q + 1'b1;
        if (idx_q == IDX_W'(NUM_BRICKS - 1)) state_d = DONE;
      end
      DONE: begin
        det_d   = acc_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.collision_det = det_q;
  assign bus.det_valid     = valid_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_ball_collision_det.sv
// Directed bench for ball_collision_det: hand-computed hit vectors, pulse
// timing, input latching, mid-scan reset and back-to-back scans.
module tb_ball_collision_det;
  import ball_game_pkg::*;

  logic pclk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  ball_collision_det_if bus ();

  ball_collision_det dut (
    .pclk (pclk),
    .reset(rst),
    .bus  (bus.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Drive a request so it is sampled at the next posedge (edge k); returns #1 after k.
  task automatic issue_scan(input logic [11:0] x, input logic [11:0] y,
                            input logic [15:0] alive);
    @(negedge pclk);
    bus.x_pos       = x;
    bus.y_pos       = y;
    bus.brick_alive = alive;
    bus.scan_start  = 1'b1;
    @(posedge pclk);
    #1;
    bus.scan_start = 1'b0;
  endtask

  // Watch 20 cycles after edge k; report first pulse latency, pulse count, result.
  task automatic watch_scan(output int lat, output int pulses,
                            output logic [15:0] res, output logic [20:0] busy_bits);
    lat = -1; pulses = 0; res = '0; busy_bits = '0;
    busy_bits[0] = bus.busy;
    for (int c = 1; c <= 20; c++) begin
      @(posedge pclk);
      #1;
      busy_bits[c] = bus.busy;
      if (bus.det_valid === 1'b1) begin
        pulses++;
        if (lat < 0) lat = c;
        res = bus.collision_det;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.scan_start = 1'b0; bus.x_pos = '0; bus.y_pos = '0; bus.brick_alive = '0;
    repeat (3) @(posedge pclk);
    #1;
    n_cmp++; if (bus.collision_det !== 16'h0000) begin n_bad++; $display("FAIL reset_det got %h want 0000", bus.collision_det); end
    n_cmp++; if (bus.det_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", bus.det_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.dbg_state !== IDLE) begin n_bad++; $display("FAIL reset_state got %0d want IDLE", bus.dbg_state); end
    @(negedge pclk);
    rst = 1'b0;
  endtask

  task automatic run_check(input string name, input logic [11:0] x, input logic [11:0] y,
                           input logic [15:0] alive, input logic [15:0] exp);
    int lat, pulses; logic [15:0] res; logic [20:0] bb;
    issue_scan(x, y, alive);
    watch_scan(lat, pulses, res, bb);
    n_cmp++; if (res !== exp) begin n_bad++; $display("FAIL %s_result got %h want %h", name, res, exp); end
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL %s_latency got %0d want 17", name, lat); end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL %s_pulses got %0d want 1", name, pulses); end
    n_cmp++; if (bus.collision_det !== exp) begin n_bad++; $display("FAIL %s_hold got %h want %h", name, bus.collision_det, exp); end
  endtask

  task automatic test_basic();
    int lat, pulses; logic [15:0] res; logic [20:0] bb;
    issue_scan(12'd64, 12'd74, 16'hFFFF);
    watch_scan(lat, pulses, res, bb);
    n_cmp++; if (res !== 16'h0001) begin n_bad++; $display("FAIL basic_result got %h want 0001", res); end
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL basic_latency got %0d want 17", lat); end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL basic_pulses got %0d want 1", pulses); end
    n_cmp++; if (bb[16:0] !== 17'h1FFFF) begin n_bad++; $display("FAIL basic_busy got %h want 1ffff", bb[16:0]); end
    n_cmp++; if (bb[19:18] !== 2'b00) begin n_bad++; $display("FAIL basic_idle got %b want 00", bb[19:18]); end
  endtask

  task automatic test_multi_hit();
    run_check("quad", 12'd128, 12'd100, 16'hFFFF, 16'h0303);
    run_check("dead8", 12'd128, 12'd100, 16'hFEFF, 16'h0203);
  endtask

  task automatic test_edges();
    run_check("edge_in", 12'd137, 12'd54, 16'hFFFF, 16'h0003);
    run_check("edge_out", 12'd138, 12'd50, 16'hFFFF, 16'h0000);
  endtask

  task automatic test_latching();
    int lat = -1; int pulses = 0; int busy_lo = 0; logic [15:0] res = '0;
    issue_scan(12'd64, 12'd74, 16'hFFFF);
    for (int c = 1; c <= 20; c++) begin
      @(negedge pclk);
      if (c == 3) begin bus.x_pos = 12'd500; bus.y_pos = 12'd500; end
      if (c == 5) bus.scan_start = 1'b1;
      @(posedge pclk);
      #1;
      bus.scan_start = 1'b0;
      if (c <= 16 && bus.busy !== 1'b1) busy_lo++;
      if (bus.det_valid === 1'b1) begin pulses++; if (lat < 0) lat = c; res = bus.collision_det; end
    end
    n_cmp++; if (res !== 16'h0001) begin n_bad++; $display("FAIL latch_result got %h want 0001", res); end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL latch_pulses got %0d want 1", pulses); end
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL latch_latency got %0d want 17", lat); end
    n_cmp++; if (busy_lo !== 0) begin n_bad++; $display("FAIL latch_busy low_cycles %0d want 0", busy_lo); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL latch_end_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_mid_reset();
    int pulses = 0;
    run_check("pre_rst", 12'd128, 12'd100, 16'hFFFF, 16'h0303);
    issue_scan(12'd64, 12'd74, 16'hFFFF);
    repeat (7) @(posedge pclk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.collision_det !== 16'h0000) begin n_bad++; $display("FAIL midrst_det got %h want 0000", bus.collision_det); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.dbg_state !== IDLE) begin n_bad++; $display("FAIL midrst_state got %0d want IDLE", bus.dbg_state); end
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge pclk);
      #1;
      if (bus.det_valid === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL midrst_pulses got %0d want 0", pulses); end
    run_check("post_rst", 12'd64, 12'd74, 16'hFFFF, 16'h0001);
  endtask

  task automatic test_back_to_back();
    int lat1 = -1; int lat2 = -1; int pulses = 0;
    logic [15:0] r1 = '0; logic [15:0] r2 = '0;
    issue_scan(12'd128, 12'd100, 16'hFFFF);
    for (int c = 1; c <= 40; c++) begin
      @(negedge pclk);
      if (c == 18) begin
        bus.x_pos = 12'd64; bus.y_pos = 12'd74; bus.brick_alive = 16'hFFFF;
        bus.scan_start = 1'b1;
      end
      @(posedge pclk);
      #1;
      bus.scan_start = 1'b0;
      if (bus.det_valid === 1'b1) begin
        pulses++;
        if (lat1 < 0) begin lat1 = c; r1 = bus.collision_det; end
        else begin lat2 = c; r2 = bus.collision_det; end
      end
    end
    n_cmp++; if (pulses !== 2) begin n_bad++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
    n_cmp++; if (lat1 !== 17) begin n_bad++; $display("FAIL b2b_lat1 got %0d want 17", lat1); end
    n_cmp++; if (lat2 !== 35) begin n_bad++; $display("FAIL b2b_lat2 got %0d want 35", lat2); end
    n_cmp++; if (r1 !== 16'h0303) begin n_bad++; $display("FAIL b2b_res1 got %h want 0303", r1); end
    n_cmp++; if (r2 !== 16'h0001) begin n_bad++; $display("FAIL b2b_res2 got %h want 0001", r2); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_multi_hit();
    test_edges();
    test_latching();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
